// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR / interrupt unit.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // Interrupt cause codes
    localparam int unsigned CAUSE_MEI       = 11;
    localparam int unsigned CAUSE_MTI       = 7;
    localparam int unsigned CAUSE_LIRQ_BASE = 16;

    // Bit positions
    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LSB  = 11;
    localparam int unsigned MIE_MEIE_BIT     = 11;
    localparam int unsigned MIE_MTIE_BIT     = 7;

    // Trap FSM states
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPend = 2'd1;
    localparam logic [1:0] StIsr  = 2'd2;

    // Writable bits of mie for a given number of local interrupt lines.
    function automatic logic [31:0] mie_mask(input int unsigned num_lirq);
        logic [31:0] m;
        m = '0;
        m[MIE_MEIE_BIT] = 1'b1;
        m[MIE_MTIE_BIT] = 1'b1;
        for (int unsigned i = 0; i < num_lirq && i < 16; i++) begin
            m[CAUSE_LIRQ_BASE + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable halves.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wen_lo,
    input  logic        wen_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    logic [63:0] value_q, value_d;

    // Any write to either half suppresses the increment for the whole counter.
    always_comb begin
        value_d = value_q;
        if (wen_lo || wen_hi) begin
            if (wen_lo) value_d[31:0]  = wdata;
            if (wen_hi) value_d[63:32] = wdata;
        end else if (inc) begin
            value_d = value_q + 64'd1;
        end
    end

    // Counter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and fixed-priority interrupt controller.
module csr_irq_unit
    import csr_pkg::*;
#(
    parameter int unsigned NUM_LIRQ    = 4,
    parameter logic [31:0] MTVEC_RESET = 32'h0001_0000,
    localparam int unsigned LirqW      = (NUM_LIRQ > 0) ? NUM_LIRQ : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      csr_addr,
    output logic [31:0]      csr_rdata,
    input  logic [31:0]      csr_wdata,
    input  logic             csr_wen,
    input  logic             stall,
    input  logic             retire,
    input  logic             nop,
    input  logic             wfi,
    input  logic [31:0]      pc,
    input  logic             mret,
    input  logic             meip,
    input  logic             mtip,
    input  logic [LirqW-1:0] lirq,
    output logic             trap_take,
    output logic [31:0]      trap_pc,
    output logic [31:0]      mepc_o
);

    localparam logic [31:0] MieMask = mie_mask(NUM_LIRQ);

    logic [1:0]  state_q, state_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic [1:0]  st_mpp_q, st_mpp_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mtvec_q, mtvec_d;

    logic [31:0] mip, pending, mstatus, tvec_base;
    logic [4:0]  irq_code;
    logic        irq_eligible, csr_we;
    logic [63:0] mcycle, minstret;

    // Live interrupt lines mapped onto mip bit positions
    always_comb begin
        mip = '0;
        mip[CAUSE_MEI] = meip;
        mip[CAUSE_MTI] = mtip;
        for (int i = 0; i < int'(NUM_LIRQ); i++) begin
            mip[CAUSE_LIRQ_BASE + i] = lirq[i];
        end
    end

    assign pending      = mip & mie_q;
    assign irq_eligible = st_mie_q && |pending;

    // Fixed priority: MEI > MTI > lirq[0] > lirq[1] > ...; later assignments win.
    always_comb begin
        irq_code = 5'd0;
        for (int i = int'(NUM_LIRQ) - 1; i >= 0; i--) begin
            if (pending[CAUSE_LIRQ_BASE + i]) irq_code = 5'(CAUSE_LIRQ_BASE + i);
        end
        if (pending[CAUSE_MTI]) irq_code = 5'(CAUSE_MTI);
        if (pending[CAUSE_MEI]) irq_code = 5'(CAUSE_MEI);
    end

    assign trap_take = (state_q == StPend) && !nop && !stall;
    // The trapping instruction is squashed, so its CSR write must not land.
    assign csr_we    = csr_wen && !stall && !trap_take;

    assign tvec_base = {mtvec_q[31:2], 2'b00};
    assign trap_pc   = mtvec_q[0] ? tvec_base + {mcause_q[29:0], 2'b00} : tvec_base;
    assign mepc_o    = mepc_q;

    // Trap FSM and CSR next-state; software writes are applied last so they win.
    always_comb begin
        state_d    = state_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        st_mpp_d   = st_mpp_q;
        mie_d      = mie_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mscratch_d = mscratch_q;
        mtvec_d    = mtvec_q;
        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (irq_eligible) begin
                        state_d   = StPend;
                        st_mpie_d = st_mie_q;
                        st_mie_d  = 1'b0;
                        st_mpp_d  = 2'b11;
                        mcause_d  = {1'b1, 26'd0, irq_code};
                    end
                end
                StPend: begin
                    if (!nop) begin
                        state_d = StIsr;
                        mepc_d  = wfi ? pc + 32'd4 : pc;
                    end
                end
                StIsr: begin
                    if (mret) begin
                        state_d   = StIdle;
                        st_mie_d  = st_mpie_q;
                        st_mpie_d = 1'b1;
                        st_mpp_d  = 2'b11;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    st_mie_d  = csr_wdata[MSTATUS_MIE_BIT];
                    st_mpie_d = csr_wdata[MSTATUS_MPIE_BIT];
                    st_mpp_d  = csr_wdata[MSTATUS_MPP_LSB +: 2];
                end
                CSR_MIE:      mie_d      = csr_wdata & MieMask;
                CSR_MTVEC:    mtvec_d    = csr_wdata & ~32'h0000_0002;
                CSR_MSCRATCH: mscratch_d = csr_wdata;
                CSR_MEPC:     mepc_d     = csr_wdata;
                CSR_MCAUSE:   mcause_d   = csr_wdata;
                default:      ;
            endcase
        end
    end

    // CSR and FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            st_mpp_q   <= 2'b00;
            mie_q      <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mscratch_q <= '0;
            mtvec_q    <= MTVEC_RESET;
        end else begin
            state_q    <= state_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            st_mpp_q   <= st_mpp_d;
            mie_q      <= mie_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mscratch_q <= mscratch_d;
            mtvec_q    <= mtvec_d;
        end
    end

    // mcycle also counts stall cycles; minstret only counts unstalled retirements.
    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc    (1'b1),
        .wen_lo (csr_we && csr_addr == CSR_MCYCLE),
        .wen_hi (csr_we && csr_addr == CSR_MCYCLEH),
        .wdata  (csr_wdata),
        .value  (mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc    (retire && !stall),
        .wen_lo (csr_we && csr_addr == CSR_MINSTRET),
        .wen_hi (csr_we && csr_addr == CSR_MINSTRETH),
        .wdata  (csr_wdata),
        .value  (minstret)
    );

    assign mstatus = {19'd0, st_mpp_q, 3'd0, st_mpie_q, 3'd0, st_mie_q, 3'd0};

    // Combinational read mux; unmapped addresses read zero.
    always_comb begin
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus;
            CSR_MIE:       csr_rdata = mie_q;
            CSR_MTVEC:     csr_rdata = mtvec_q;
            CSR_MSCRATCH:  csr_rdata = mscratch_q;
            CSR_MEPC:      csr_rdata = mepc_q;
            CSR_MCAUSE:    csr_rdata = mcause_q;
            CSR_MIP:       csr_rdata = mip;
            CSR_MCYCLE:    csr_rdata = mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
            CSR_MINSTRET:  csr_rdata = minstret[31:0];
            CSR_MINSTRETH: csr_rdata = minstret[63:32];
            default:       csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed self-checking bench for csr_irq_unit.
module tb_csr_irq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic [31:0] csr_wdata;
    logic        csr_wen;
    logic        stall;
    logic        retire;
    logic        nop;
    logic        wfi;
    logic [31:0] pc;
    logic        mret;
    logic        meip;
    logic        mtip;
    logic [3:0]  lirq;
    logic        trap_take;
    logic [31:0] trap_pc;
    logic [31:0] mepc_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] m0;

    csr_irq_unit #(
        .NUM_LIRQ    (4),
        .MTVEC_RESET (32'h0001_0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_addr  (csr_addr),
        .csr_rdata (csr_rdata),
        .csr_wdata (csr_wdata),
        .csr_wen   (csr_wen),
        .stall     (stall),
        .retire    (retire),
        .nop       (nop),
        .wfi       (wfi),
        .pc        (pc),
        .mret      (mret),
        .meip      (meip),
        .mtip      (mtip),
        .lirq      (lirq),
        .trap_take (trap_take),
        .trap_pc   (trap_pc),
        .mepc_o    (mepc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        @(posedge clk);
        #1;
        csr_wen = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; csr_addr = '0; csr_wdata = '0; csr_wen = 1'b0; stall = 1'b0;
        retire = 1'b0; nop = 1'b0; wfi = 1'b0; pc = '0; mret = 1'b0;
        meip = 1'b0; mtip = 1'b0; lirq = '0;
        #22 rst = 1'b0;
        #1;

        // Reset state
        check("rst_trap_take", 32'(trap_take), 32'd0);
        check("rst_mepc_o", mepc_o, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0001_0000);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);

        // mip is live and read-only; unmapped reads are zero
        meip = 1'b1; lirq = 4'b0101;
        rd("mip_live", 12'h344, 32'h0005_0800);
        wr(12'h344, 32'hFFFF_FFFF);
        rd("mip_ro", 12'h344, 32'h0005_0800);
        rd("unmapped", 12'h7C0, 32'h0);
        meip = 1'b0; lirq = '0;

        // 1: external interrupt, direct mode
        wr(12'h300, 32'h8);
        wr(12'h304, 32'hFFFF_FFFF);
        rd("mie_mask", 12'h304, 32'h000F_0880);
        wr(12'h304, 32'h800);
        meip = 1'b1; pc = 32'h200;
        #1;
        check("t1_no_trap_yet", 32'(trap_take), 32'd0);
        step();
        check("t1_trap_take", 32'(trap_take), 32'd1);
        check("t1_trap_pc", trap_pc, 32'h0001_0000);
        rd("t1_mcause", 12'h342, 32'h8000_000B);
        rd("t1_mstatus", 12'h300, 32'h0000_1880);
        // Write in the squashed slot must be dropped
        csr_addr = 12'h340; csr_wdata = 32'h55; csr_wen = 1'b1;
        step();
        csr_wen = 1'b0;
        check("t1_mepc", mepc_o, 32'h200);
        check("t1_pulse_end", 32'(trap_take), 32'd0);
        rd("t1_squash", 12'h340, 32'h0);
        meip = 1'b0; mret = 1'b1;
        step();
        mret = 1'b0;
        rd("t1_mret_mstatus", 12'h300, 32'h0000_1888);
        wr(12'h340, 32'hCAFE_F00D);
        rd("mscratch", 12'h340, 32'hCAFE_F00D);

        // 2: vectored mode, MTI beats lirq[2], then lirq[2]
        wr(12'h305, 32'h0001_0003);
        rd("mtvec_bit1", 12'h305, 32'h0001_0001);
        wr(12'h304, 32'h0004_0080);
        mtip = 1'b1; lirq = 4'b0100;
        step();
        check("t2_take_mti", 32'(trap_take), 32'd1);
        check("t2_pc_mti", trap_pc, 32'h0001_001C);
        rd("t2_cause_mti", 12'h342, 32'h8000_0007);
        step();
        mtip = 1'b0; mret = 1'b1;
        step();
        mret = 1'b0;
        check("t2_idle_gap", 32'(trap_take), 32'd0);
        step();
        check("t2_take_lirq", 32'(trap_take), 32'd1);
        check("t2_pc_lirq", trap_pc, 32'h0001_0048);
        rd("t2_cause_lirq", 12'h342, 32'h8000_0012);
        step();
        lirq = '0; mret = 1'b1;
        step();
        mret = 1'b0;
        wr(12'h305, 32'h0001_0000);
        wr(12'h304, 32'h800);

        // 3: PEND held by bubbles, then WFI
        nop = 1'b1; meip = 1'b1;
        step();
        meip = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("t3_hold", 32'(trap_take), 32'd0);
            step();
        end
        nop = 1'b0; wfi = 1'b1; pc = 32'h300;
        #1;
        check("t3_take", 32'(trap_take), 32'd1);
        rd("t3_cause", 12'h342, 32'h8000_000B);
        step();
        wfi = 1'b0;
        check("t3_mepc", mepc_o, 32'h304);
        mret = 1'b1;
        step();
        mret = 1'b0;

        // 4: stall freezes FSM, minstret and CSR writes; mcycle keeps counting
        stall = 1'b1; meip = 1'b1; retire = 1'b1;
        csr_addr = 12'hB00;
        #1;
        m0 = csr_rdata;
        csr_addr = 12'h340; csr_wdata = 32'hDEAD; csr_wen = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t4_stall_no_trap", 32'(trap_take), 32'd0);
        end
        csr_wen = 1'b0;
        rd("t4_mcycle", 12'hB00, m0 + 32'd5);
        rd("t4_minstret", 12'hB02, 32'h0);
        rd("t4_mstatus", 12'h300, 32'h0000_1888);
        rd("t4_write_dropped", 12'h340, 32'hCAFE_F00D);
        stall = 1'b0; retire = 1'b0;
        step();
        check("t4_release_take", 32'(trap_take), 32'd1);
        step();
        meip = 1'b0; mret = 1'b1;
        step();
        mret = 1'b0; retire = 1'b1;
        step();
        step();
        retire = 1'b0;
        rd("t4_minstret_2", 12'hB02, 32'd2);

        // 5: mcycle wrap and write suppression
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'hFFFF_FFFF);
        rd("t5_lo_ones", 12'hB00, 32'hFFFF_FFFF);
        rd("t5_hi_ones", 12'hB80, 32'hFFFF_FFFF);
        step();
        rd("t5_lo_wrap", 12'hB00, 32'h0);
        rd("t5_hi_wrap", 12'hB80, 32'h0);
        wr(12'hB80, 32'h1234);
        rd("t5_hi_written", 12'hB80, 32'h1234);
        rd("t5_lo_no_inc", 12'hB00, 32'h0);

        // 6: reset while in ISR
        wr(12'h305, 32'h0002_0001);
        meip = 1'b1;
        step();
        step();
        check("t6_in_isr", mepc_o, 32'h300);
        #2 rst = 1'b1;
        #1;
        check("t6_trap_take", 32'(trap_take), 32'd0);
        check("t6_mepc", mepc_o, 32'h0);
        rd("t6_mtvec", 12'h305, 32'h0001_0000);
        rd("t6_mie", 12'h304, 32'h0);
        rd("t6_mstatus", 12'h300, 32'h0);
        rd("t6_mcycle_lo", 12'hB00, 32'h0);
        rd("t6_mcycle_hi", 12'hB80, 32'h0);
        rd("t6_minstret", 12'hB02, 32'h0);
        step();
        rst = 1'b0;
        // FSM must be back in IDLE: a fresh interrupt is taken normally
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        check("t6_idle_gap", 32'(trap_take), 32'd0);
        step();
        check("t6_retake", 32'(trap_take), 32'd1);
        check("t6_retake_pc", trap_pc, 32'h0001_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
